frame_tx_scheduler: RTL
=======================

Name: frame_tx_scheduler

Overview:
- Sequences one status frame per period into the UART transmitter: header byte 0xFF, one ON/OFF byte per switch channel, then one frequency byte.
- Applies the link byte encoding: 0xFF = start of frame, 1 = switch ON, 2 = switch OFF, values 20..254 = frequency.
- Sits between the switch/frequency sources and the UART TX byte interface (valid/ready).

Parameters:
- NUM_SW, 4, number of switch channels per frame (1..16).
- FRAME_PERIOD, 50000000, clock cycles between periodic frame triggers (>= NUM_SW+3).
- CNT_W, 26, width of period counter; must hold FRAME_PERIOD-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-low.
- enable  in  1  periodic triggering enabled.
- force_send  in  1  one-cycle request for an immediate frame.
- sw_state  in  NUM_SW  switch levels; 1 = ON.
- freq_data  in  8  current frequency value.
- tx_data  out  8  byte to UART TX.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART accepts byte this cycle.
- busy  out  1  frame in progress (state != IDLE).
- frame_done  out  1  one-cycle pulse after the last byte is accepted.
- overrun  out  1  sticky: a trigger was dropped.
- frame_cnt  out  8  completed frames, wraps 255->0.

Behaviour:
- Reset (reset=0 at clk edge): state IDLE; tx_data=0, tx_valid=0, busy=0, frame_done=0, overrun=0, frame_cnt=0; period counter=0; pending=0. A mid-frame reset drops tx_valid on the next edge and abandons the frame without completing it.
- Period counter:
  - While enable=1, counts 0..FRAME_PERIOD-1 and raises tick at terminal count, then wraps to 0.
  - While enable=0, held at 0 and pending cleared; a frame already in progress still completes.
- Trigger: trigger = tick | force_send.
  - In IDLE, a trigger starts a frame.
  - While busy, a trigger sets pending. A trigger arriving while pending=1 is dropped and sets overrun.
  - On leaving DONE with pending=1, the next frame starts immediately and pending clears.
- Snapshot: sw_state and freq_data are registered in the cycle the frame starts; later input changes do not affect that frame.
- State machine:
  - IDLE -> HDR on start.
  - HDR: tx_data=0xFF -> SW on accept.
  - SW: channel index i from 0 to NUM_SW-1; tx_data = 1 if snapshot bit i else 2. Advances i on each accept; after i=NUM_SW-1 is accepted -> FREQ.
  - FREQ: tx_data = clamp(freq) -> DONE on accept.
  - DONE: frame_done=1 for exactly one cycle, frame_cnt+1 -> IDLE, or -> HDR if pending.
- Frequency clamp: freq < 20 -> 20; freq = 0xFF -> 0xFE; otherwise unchanged. A frequency byte can never alias a switch code or the header.
- Handshake:
  - tx_valid and tx_data are registered outputs.
  - A byte transfers on a cycle where tx_valid & tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data is held stable.
  - tx_valid stays high across back-to-back bytes within a frame.
  - tx_valid=0 in IDLE and DONE.
- Latency:
  - Trigger at edge T -> tx_valid=1 with 0xFF at T+1.
  - With tx_ready tied to 1, a frame occupies NUM_SW+2 valid cycles plus 1 DONE cycle.
- Simultaneous events: tick and force_send in the same cycle count as one trigger. Reset has priority over everything.

Decomposition:
- Shared package: link codes HDR_BYTE=8'hFF, SW_ON=8'd1, SW_OFF=8'd2, FREQ_MIN=8'd20, FREQ_MAX=8'd254; state enum {IDLE,HDR,SW,FREQ,DONE}.
- One natural sub-module: frame_period_timer, containing the period counter, tick generation and enable gating.

Test Plan:
- NUM_SW=4, tx_ready=1, force_send pulse with sw_state=4'b0101, freq_data=100 -> bytes FF,01,02,01,02,64 on consecutive cycles; frame_done pulses once; frame_cnt=1.
- freq_data=5, then freq_data=255 on separate frames -> frequency bytes 0x14 and 0xFE.
- tx_ready low for 3 cycles during SW byte for channel 1 -> tx_data held at 02 with tx_valid=1; sequence resumes unchanged.
- Two force_send pulses during a frame, then a third -> exactly one back-to-back frame follows (HDR the cycle after DONE); overrun=1.
- FRAME_PERIOD=20, enable=1 for 100 cycles, tx_ready=1 -> 5 frames, first header at cycle 20; enable dropped mid-frame -> frame completes, no further frames.
- reset=0 asserted during FREQ state -> next cycle tx_valid=0, busy=0, frame_cnt=0; the following force_send produces a full fresh frame.

Source files
------------

// File: rtl/frame_tx_scheduler_pkg.sv
// Link byte codes, scheduler states and the frequency clamp shared by the
// frame scheduler and its bench.
package frame_tx_scheduler_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hFF;
    localparam logic [7:0] SW_ON    = 8'd1;
    localparam logic [7:0] SW_OFF   = 8'd2;
    localparam logic [7:0] FREQ_MIN = 8'd20;
    localparam logic [7:0] FREQ_MAX = 8'd254;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        SW   = 3'd2,
        FREQ = 3'd3,
        DONE = 3'd4
    } state_t;

    // Keeps a frequency byte out of the switch-code and header ranges.
    function automatic logic [7:0] clamp_freq(input logic [7:0] f);
        if (f < FREQ_MIN) begin
            return FREQ_MIN;
        end else if (f > FREQ_MAX) begin
            return FREQ_MAX;
        end else begin
            return f;
        end
    endfunction

endpackage

// File: rtl/frame_period_timer.sv
// Free-running frame period counter; tick is high during the terminal count
// cycle and the counter is parked at zero whenever enable is low.
module frame_period_timer #(
    parameter int FRAME_PERIOD = 50000000,
    parameter int CNT_W        = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset || !enable) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/frame_tx_scheduler.sv
// Emits one status frame (header, per-switch ON/OFF codes, clamped frequency)
// to the UART TX byte interface per periodic or forced trigger.
module frame_tx_scheduler
    import frame_tx_scheduler_pkg::*;
#(
    parameter int NUM_SW       = 4,
    parameter int FRAME_PERIOD = 50000000,
    parameter int CNT_W        = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              force_send,
    input  logic [NUM_SW-1:0] sw_state,
    input  logic [7:0]        freq_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun,
    output logic [7:0]        frame_cnt,
    output state_t            state_dbg
);

    localparam int IDX_W = (NUM_SW > 1) ? $clog2(NUM_SW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SW - 1);

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  sw_idx;
    logic [IDX_W-1:0]  sw_idx_next;
    logic [NUM_SW-1:0] snap_sw;
    logic [7:0]        snap_freq;
    logic              pending;
    logic              tick;
    logic              trigger;
    logic              accept;
    logic              start;
    logic [7:0]        tx_data_next;
    logic              tx_valid_next;

    frame_period_timer #(
        .FRAME_PERIOD (FRAME_PERIOD),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    // Handshake: a byte moves on every cycle with tx_valid & tx_ready; while
    // tx_valid is high and tx_ready low, tx_data and tx_valid hold unchanged.
    assign trigger = tick | force_send;
    assign accept  = tx_valid & tx_ready;
    assign start   = (state_next == HDR) && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            sw_idx <= '0;
        end else begin
            state  <= state_next;
            sw_idx <= sw_idx_next;
        end
    end

    always_comb begin
        state_next  = state;
        sw_idx_next = sw_idx;
        case (state)
            IDLE: if (trigger) state_next = HDR;
            HDR: begin
                if (accept) begin
                    state_next  = SW;
                    sw_idx_next = '0;
                end
            end
            SW: begin
                if (accept) begin
                    if (sw_idx == LAST_IDX) state_next = FREQ;
                    else                    sw_idx_next = sw_idx + 1'b1;
                end
            end
            FREQ: if (accept) state_next = DONE;
            // A trigger landing in DONE with nothing queued starts the next frame directly.
            DONE: state_next = (pending || trigger) ? HDR : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != IDLE);
        frame_done    = (state == DONE);
        state_dbg     = state;
        tx_valid_next = 1'b0;
        tx_data_next  = 8'h00;
        case (state_next)
            HDR: begin
                tx_valid_next = 1'b1;
                tx_data_next  = HDR_BYTE;
            end
            SW: begin
                tx_valid_next = 1'b1;
                tx_data_next  = snap_sw[sw_idx_next] ? SW_ON : SW_OFF;
            end
            FREQ: begin
                tx_valid_next = 1'b1;
                tx_data_next  = clamp_freq(snap_freq);
            end
            default: begin
                tx_valid_next = 1'b0;
                tx_data_next  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            snap_sw   <= '0;
            snap_freq <= 8'h00;
            pending   <= 1'b0;
            overrun   <= 1'b0;
            frame_cnt <= 8'h00;
        end else begin
            tx_valid <= tx_valid_next;
            tx_data  <= tx_data_next;
            if (start) begin
                snap_sw   <= sw_state;
                snap_freq <= freq_data;
            end
            if (state == DONE) frame_cnt <= frame_cnt + 1'b1;
            if (busy && trigger && pending) overrun <= 1'b1;
            if (!enable || state == DONE) begin
                pending <= 1'b0;
            end else if (busy && trigger) begin
                pending <= 1'b1;
            end
        end
    end

endmodule
